// File: rtl/gamma_loader.sv
// Gamma LUT loader: fills 3x256 gamma entries from a byte stream or as an
// identity ramp, and keeps gamma_en low while the table is incomplete.
module gamma_loader #(
    parameter int ENTRIES = 768,
    parameter bit RAMP_EN = 1'b1
) (
    input  logic        clk_sys,
    input  logic        reset,
    inout  wire  [21:0] gamma_bus,
    input  logic        enable,
    input  logic        load_file,
    input  logic        load_ramp,
    input  logic        abort,
    input  logic        s_valid,
    input  logic [7:0]  s_data,
    output logic        s_ready,
    output logic        busy,
    output logic        done,
    output logic        loaded,
    output logic        error
);

    localparam int NW = $clog2(ENTRIES);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        RAMP   = 2'd2,
        FIN    = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [NW-1:0]   n_q, n_d;
    logic [7:0]      idx_q, idx_d;
    logic [1:0]      ch_q, ch_d;
    logic            wr_q, wr_d;
    logic [9:0]      addr_q, addr_d;
    logic [7:0]      val_q, val_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            loaded_q, loaded_d;
    logic            error_q, error_d;
    logic            en_q, en_d;

    logic            sup;
    logic            start_ramp;
    logic            last;

    assign sup        = gamma_bus[21];
    assign start_ramp = load_ramp & RAMP_EN & ~load_file;
    assign last       = (n_q == NW'(ENTRIES - 1));

    assign gamma_bus[20:0] = {clk_sys, en_q, wr_q, addr_q, val_q};

    assign busy   = busy_q;
    assign done   = done_q;
    assign loaded = loaded_q;
    assign error  = error_q;

    always_comb begin
        state_d  = state_q;
        n_d      = n_q;
        idx_d    = idx_q;
        ch_d     = ch_q;
        wr_d     = 1'b0;
        addr_d   = addr_q;
        val_d    = val_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        loaded_d = loaded_q;
        error_d  = error_q;
        s_ready  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (load_file || start_ramp) begin
                    n_d      = '0;
                    idx_d    = '0;
                    ch_d     = '0;
                    loaded_d = 1'b0;
                    error_d  = 1'b0;
                    busy_d   = 1'b1;
                    if (!sup)
                        state_d = FIN;
                    else if (load_file)
                        state_d = STREAM;
                    else
                        state_d = RAMP;
                end
            end
            STREAM, RAMP: begin
                // abort also blocks the handshake, so no write follows it
                s_ready = (state_q == STREAM) && !abort;
                if (abort) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    error_d = 1'b1;
                end else if (state_q == RAMP || s_valid) begin
                    wr_d   = 1'b1;
                    addr_d = {ch_q, idx_q};
                    val_d  = (state_q == RAMP) ? idx_q : s_data;
                    n_d    = n_q + 1'b1;
                    if (ch_q == 2'd2) begin
                        ch_d  = 2'd0;
                        idx_d = idx_q + 8'd1;
                    end else begin
                        ch_d = ch_q + 2'd1;
                    end
                    if (last)
                        state_d = FIN;
                end
            end
            FIN: begin
                done_d   = 1'b1;
                busy_d   = 1'b0;
                loaded_d = sup;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // loaded_q in the term holds gamma_en off until the cycle after done
    assign en_d = enable & sup & loaded_q & loaded_d & ~busy_q;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            n_q      <= '0;
            idx_q    <= '0;
            ch_q     <= '0;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            val_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            loaded_q <= 1'b0;
            error_q  <= 1'b0;
            en_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            n_q      <= n_d;
            idx_q    <= idx_d;
            ch_q     <= ch_d;
            wr_q     <= wr_d;
            addr_q   <= addr_d;
            val_q    <= val_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            loaded_q <= loaded_d;
            error_q  <= error_d;
            en_q     <= en_d;
        end
    end

endmodule

// File: tb/tb_gamma_loader.sv
// Scoreboard bench for gamma_loader: stimulus queues expected LUT writes,
// a negedge monitor pops and compares each write pulse seen on gamma_bus.
module tb_gamma_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sup = 1'b1;
    wire  [21:0] gamma_bus;
    logic        enable = 1'b0;
    logic        load_file = 1'b0;
    logic        load_ramp = 1'b0;
    logic        abort = 1'b0;
    logic        s_valid = 1'b0;
    logic [7:0]  s_data = 8'd0;
    logic        s_ready;
    logic        busy;
    logic        done;
    logic        loaded;
    logic        error;

    assign gamma_bus[21] = sup;

    wire       gen   = gamma_bus[19];
    wire       gwr   = gamma_bus[18];
    wire [9:0] gaddr = gamma_bus[17:8];
    wire [7:0] gval  = gamma_bus[7:0];

    gamma_loader #(.ENTRIES(768), .RAMP_EN(1'b1)) dut (
        .clk_sys   (clk),
        .reset     (reset),
        .gamma_bus (gamma_bus),
        .enable    (enable),
        .load_file (load_file),
        .load_ramp (load_ramp),
        .abort     (abort),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .s_ready   (s_ready),
        .busy      (busy),
        .done      (done),
        .loaded    (loaded),
        .error     (error)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        int         cyc;
        logic [9:0] addr;
        logic [7:0] val;
    } wr_t;

    wr_t exp_q[$];
    wr_t em;
    int  cyc = 0;
    int  nchk = 0;
    int  errs = 0;
    int  wcount = 0;
    int  dcount = 0;
    int  last_hs = 0;
    bit  ign = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (done) dcount++;
        if (!ign && gwr) begin
            wcount++;
            nchk++;
            if (exp_q.size() == 0) begin
                errs++;
                $display("FAIL wr_unexpected cyc=%0d addr=%h val=%h want no write",
                         cyc, gaddr, gval);
            end else begin
                em = exp_q.pop_front();
                if (em.cyc != cyc || em.addr != gaddr || em.val != gval) begin
                    errs++;
                    $display("FAIL wr cyc/addr/val got %0d/%h/%h want %0d/%h/%h",
                             cyc, gaddr, gval, em.cyc, em.addr, em.val);
                end
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s got %0d want %0d", nm, act, exp);
        end
    endtask

    function automatic logic [9:0] fa(input int n);
        return 10'((n % 3) * 256 + n / 3);
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input bit ramp, output int s);
        tick();
        if (ramp) load_ramp = 1'b1;
        else load_file = 1'b1;
        s = cyc;
        tick();
        load_ramp = 1'b0;
        load_file = 1'b0;
    endtask

    task automatic stream(input bit gaps, input int cnt);
        int n = 0;
        int t = 0;
        while (n < cnt && t < 6000) begin
            s_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            s_data  = 8'(n * 7 + 3);
            @(negedge clk);
            if (s_valid && s_ready) begin
                exp_q.push_back('{cyc + 1, fa(n), 8'(n * 7 + 3)});
                last_hs = cyc;
                n++;
            end
            tick();
            t++;
        end
        s_valid = 1'b0;
        chk("stream_count", n, cnt);
    endtask

    task automatic push_ramp(input int s);
        for (int i = 0; i < 768; i++)
            exp_q.push_back('{s + 2 + i, fa(i), 8'(i / 3)});
    endtask

    task automatic wait_done(input string nm, input int exp);
        int t = 0;
        @(negedge clk);
        while (!done && t < 1000) begin
            @(negedge clk);
            t++;
        end
        chk(nm, done ? cyc : -1, exp);
    endtask

    initial begin
        int s;
        int w0;
        int d0;
        bit bad;
        bit seen;
        int dc;

        repeat (3) tick();
        @(negedge clk);
        chk("reset_outs", int'({gamma_bus[19:0], s_ready, busy, done, loaded, error}), 0);
        tick();
        reset = 1'b0;

        // 1: stream with s_valid held high
        w0 = wcount;
        pulse_start(1'b0, s);
        stream(1'b0, 768);
        wait_done("t1_done_cyc", last_hs + 2);
        chk("t1_loaded", int'(loaded), 1);
        chk("t1_busy", int'(busy), 0);
        chk("t1_writes", wcount - w0, 768);
        chk("t1_q_empty", exp_q.size(), 0);

        // 2: stream with random gaps
        w0 = wcount;
        pulse_start(1'b0, s);
        stream(1'b1, 768);
        wait_done("t2_done_cyc", last_hs + 2);
        chk("t2_loaded", int'(loaded), 1);
        chk("t2_writes", wcount - w0, 768);
        chk("t2_q_empty", exp_q.size(), 0);

        // 3: ramp with enable high
        enable = 1'b1;
        tick();
        tick();
        @(negedge clk);
        chk("t3_en_before", int'(gen), 1);
        tick();
        load_ramp = 1'b1;
        s = cyc;
        push_ramp(s);
        @(negedge clk);
        chk("t3_en_start_cyc", int'(gen), 1);
        tick();
        load_ramp = 1'b0;
        @(negedge clk);
        chk("t3_en_drop", int'(gen), 0);
        bad = 1'b0;
        dc = -1;
        for (int t = 0; t < 900 && dc < 0; t++) begin
            @(negedge clk);
            if (busy && gen) bad = 1'b1;
            if (done) dc = cyc;
        end
        chk("t3_en_while_busy", int'(bad), 0);
        chk("t3_done_cyc", dc, s + 770);
        chk("t3_en_at_done", int'(gen), 0);
        chk("t3_loaded", int'(loaded), 1);
        @(negedge clk);
        chk("t3_en_after_done", int'(gen), 1);
        chk("t3_q_empty", exp_q.size(), 0);

        // 4: abort after 100 bytes
        pulse_start(1'b0, s);
        stream(1'b0, 100);
        d0 = dcount;
        s_valid = 1'b1;
        s_data  = 8'hAA;
        abort   = 1'b1;
        @(negedge clk);
        chk("t4_ready_abort", int'(s_ready), 0);
        tick();
        abort   = 1'b0;
        s_valid = 1'b0;
        repeat (5) @(negedge clk);
        chk("t4_error", int'(error), 1);
        chk("t4_loaded", int'(loaded), 0);
        chk("t4_busy", int'(busy), 0);
        chk("t4_gen", int'(gen), 0);
        chk("t4_no_done", dcount - d0, 0);
        chk("t4_q_empty", exp_q.size(), 0);

        // 5: gamma unsupported
        sup = 1'b0;
        w0 = wcount;
        tick();
        load_file = 1'b1;
        s = cyc;
        seen = 1'b0;
        dc = -1;
        tick();
        load_file = 1'b0;
        s_valid = 1'b1;
        for (int t = 0; t < 8; t++) begin
            @(negedge clk);
            if (s_ready) seen = 1'b1;
            if (done && dc < 0) dc = cyc;
        end
        s_valid = 1'b0;
        chk("t5_done_cyc", dc, s + 2);
        chk("t5_ready_seen", int'(seen), 0);
        chk("t5_loaded", int'(loaded), 0);
        chk("t5_error_cleared", int'(error), 0);
        chk("t5_writes", wcount - w0, 0);
        sup = 1'b1;

        // 6: reset during ramp, then a clean ramp
        ign = 1'b1;
        pulse_start(1'b1, s);
        repeat (20) tick();
        #2;
        reset = 1'b1;
        #1;
        chk("t6_async_reset",
            int'({gamma_bus[19:0], s_ready, busy, done, loaded, error}), 0);
        tick();
        reset = 1'b0;
        exp_q.delete();
        ign = 1'b0;
        tick();
        load_ramp = 1'b1;
        s = cyc;
        push_ramp(s);
        tick();
        load_ramp = 1'b0;
        wait_done("t6_done_cyc", s + 770);
        chk("t6_loaded", int'(loaded), 1);
        chk("t6_q_empty", exp_q.size(), 0);

        // enable toggled in IDLE lands one cycle later
        tick();
        tick();
        enable = 1'b0;
        @(negedge clk);
        chk("en_hold_cyc", int'(gen), 1);
        @(negedge clk);
        chk("en_off", int'(gen), 0);

        $display("Result: errors=%0d of %0d checks", errs, nchk);
        $finish;
    end

endmodule
